// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the MEM-stage data-memory port.
// Serves one access at a time with a fixed latency. While the access is in
// flight it stalls the pipeline. Reads update dm_out on the edge into DONE.
module dm_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_in,
  output logic [15:0] dm_out,
  output logic        dm_stall,
  output logic        dm_valid
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } req_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  req_t        req_q, new_req, cur;
  logic        re_in, we_in, req, commit;
  logic [15:0] addr_unused;
  logic [15:0] mem [DEPTH];

  // Upper address bits alias away; keep the full bus visibly consumed.
  assign addr_unused = dm_addr;

  // Decode the incoming request. X/Z on the strobes is not a request.
  always_comb begin
    re_in   = (dm_re === 1'b1);
    we_in   = (dm_we === 1'b1);
    req     = re_in | we_in;
    new_req = '{wr: we_in, addr: dm_addr[ADDR_W-1:0], data: dm_in};
    // With LATENCY==1 the commit happens on the accept edge, so use the live inputs.
    cur     = (state == IDLE) ? new_req : req_q;
  end

  // Next-state and countdown logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req) begin
        cnt_nx   = LAT_M1;
        state_nx = (LATENCY == 1) ? DONE : BUSY;
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The access takes effect on the edge that enters DONE.
  assign commit   = (state_nx == DONE);
  assign dm_valid = (state == DONE);
  // Stall is gated by reset so a held request during reset does not freeze the pipe.
  assign dm_stall = rst_n & (((state == IDLE) & req) | (state == BUSY));

  // State, counter, latched request and read-data register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      req_q  <= '0;
      dm_out <= 16'h0000;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req) req_q <= new_req;
      if (commit && !cur.wr) dm_out <= mem[cur.addr];
    end
  end

  // Storage array; not reset, and a reset edge never commits a write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && cur.wr) mem[cur.addr] <= cur.data;
  end

endmodule
